ysyx_23060187_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the ysyx_23060187 core. It owns the program counter, issues one outstanding request at a time to instruction memory over a valid/ready handshake, and buffers the returned word for decode. It also applies redirects (jal/jalr/taken branches) from execute, squashing any wrong-path fetch in flight. It replaces free-running per-cycle PC update with a stall-tolerant, multi-cycle fetch loop.

---
 rtl/ysyx_23060187_fetch_pkg.sv | 32 +++
 rtl/ysyx_23060187_fetch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ysyx_23060187_fetch_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060187_fetch_pkg.sv
// Shared types and constants for the ysyx_23060187 instruction-fetch sequencer.
// Optional misaligned-redirect fault support is selected with YSYX_23060187_FETCH_MISALIGN_EN.
package ysyx_23060187_fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef YSYX_23060187_FETCH_MISALIGN_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_FAULT
    } fetch_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetch_state_e;
`endif

    // Sequential successor of a fetch address; wraps naturally at 2^XLEN.
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/ysyx_23060187_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem request in flight,
// buffers the returned word for decode and applies redirects from execute.
// Define YSYX_23060187_FETCH_MISALIGN_EN to trap misaligned redirect targets in a
// sticky FAULT state; otherwise the target's low two bits are ignored.
module ysyx_23060187_fetch_ctrl
    import ysyx_23060187_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [XLEN-1:0]   inst_pc,
    output logic [INST_W-1:0] inst_data,
    output logic              fetch_fault
);

    fetch_state_e      state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic [XLEN-1:0]   req_addr, req_addr_n;
    logic              drop, drop_n;
    logic [XLEN-1:0]   inst_pc_n;
    logic [INST_W-1:0] inst_data_n;
    logic              req_valid_n;
    logic              inst_valid_n;
    logic [XLEN-1:0]   redir_tgt;
    logic              misalign;

`ifdef YSYX_23060187_FETCH_MISALIGN_EN
    logic fault, fault_n;
`endif

    assign imem_req_addr = req_addr;

    // Redirect target and misalignment detection.
`ifdef YSYX_23060187_FETCH_MISALIGN_EN
    assign redir_tgt = redirect_pc;
    assign misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_tgt = redirect_pc & ~XLEN'(3);
    assign misalign  = 1'b0;
`endif

    // Next-state, PC/address update and registered-output precompute.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_addr_n  = req_addr;
        drop_n      = drop;
        inst_pc_n   = inst_pc;
        inst_data_n = inst_data;

        case (state)
            ST_IDLE: begin
                state_n = ST_REQ;
                if (redirect_valid) begin
                    pc_n       = redir_tgt;
                    req_addr_n = redir_tgt;
                end else begin
                    req_addr_n = pc;
                end
            end
            ST_REQ: begin
                // Address stays put even on redirect; the stale fetch is dropped later.
                if (imem_req_ready) begin
                    state_n = ST_WAIT;
                end
                if (redirect_valid) begin
                    pc_n   = redir_tgt;
                    drop_n = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid) begin
                        state_n    = ST_REQ;
                        pc_n       = redir_tgt;
                        req_addr_n = redir_tgt;
                        drop_n     = 1'b0;
                    end else if (drop) begin
                        state_n    = ST_REQ;
                        req_addr_n = pc;
                        drop_n     = 1'b0;
                    end else begin
                        state_n     = ST_HOLD;
                        inst_pc_n   = req_addr;
                        inst_data_n = imem_rsp_data;
                    end
                end else if (redirect_valid) begin
                    pc_n   = redir_tgt;
                    drop_n = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    state_n    = ST_REQ;
                    pc_n       = redir_tgt;
                    req_addr_n = redir_tgt;
                end else if (inst_ready) begin
                    state_n    = ST_REQ;
                    pc_n       = seq_pc(pc);
                    req_addr_n = seq_pc(pc);
                end
            end
`ifdef YSYX_23060187_FETCH_MISALIGN_EN
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase

`ifdef YSYX_23060187_FETCH_MISALIGN_EN
        // A misaligned redirect overrides everything and parks the sequencer.
        if (misalign && (state != ST_FAULT)) begin
            state_n = ST_FAULT;
            drop_n  = 1'b0;
        end
        fault_n = (state_n == ST_FAULT);
`endif

        req_valid_n  = (state_n == ST_REQ);
        inst_valid_n = (state_n == ST_HOLD);
    end

    // State, PC, buffer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            req_addr       <= RESET_PC;
            drop           <= 1'b0;
            inst_pc        <= '0;
            inst_data      <= '0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            req_addr       <= req_addr_n;
            drop           <= drop_n;
            inst_pc        <= inst_pc_n;
            inst_data      <= inst_data_n;
            imem_req_valid <= req_valid_n;
            inst_valid     <= inst_valid_n;
        end
    end

`ifdef YSYX_23060187_FETCH_MISALIGN_EN
    // Sticky fault flag; cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault <= 1'b0;
        end else begin
            fault <= fault_n;
        end
    end

    assign fetch_fault = fault;
`else
    assign fetch_fault = 1'b0;
    logic unused_misalign;
    assign unused_misalign = misalign;
`endif

endmodule

// File: tb/tb_ysyx_23060187_fetch_ctrl.sv
// Self-checking bench for ysyx_23060187_fetch_ctrl: directed scenarios followed by a
// randomized run checked against a transaction-level model of the fetch stream.
module tb_ysyx_23060187_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    // Memory model state
    logic        pend;
    logic [31:0] paddr;
    int          lat_left;
    int          lat_cfg;
    bit          lat_rand;

    always #5 clk = ~clk;

    ysyx_23060187_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3 ^ (a << 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: memory sees the handshake at the edge, then drives its response for the next cycle.
    task automatic tick();
        logic        acc;
        logic        fire;
        logic [31:0] a;
        acc  = imem_req_valid && imem_req_ready;
        fire = imem_rsp_valid;
        a    = imem_req_addr;
        @(posedge clk);
        #1;
        if (fire) pend = 1'b0;
        if (acc) begin
            pend     = 1'b1;
            paddr    = a;
            lat_left = (lat_rand ? int'($urandom_range(3, 1)) : lat_cfg) - 1;
        end else if (pend && lat_left > 0) begin
            lat_left--;
        end
        imem_rsp_valid = pend && (lat_left == 0);
        imem_rsp_data  = pend ? memword(paddr) : 32'hDEAD_BEEF;
    endtask

    task automatic wait_inst(input string tag, input int limit);
        int n = 0;
        while (!inst_valid && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(inst_valid), 32'd1);
    endtask

    task automatic wait_req(input string tag, input int limit, output logic seen_inst);
        int n = 0;
        seen_inst = 1'b0;
        while (!imem_req_valid && n < limit) begin
            tick();
            n++;
            seen_inst |= inst_valid;
        end
        chk({tag, "_timeout"}, 32'(imem_req_valid), 32'd1);
    endtask

    initial begin
        logic        seen;
        logic [31:0] exp_pc;
        logic [31:0] r;
        int          consumed;
        int          idle;
        logic        p_rv, p_rr, p_iv, p_ir, p_redir;
        logic [31:0] p_addr, p_ipc, p_idata;

        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b1;
        pend           = 1'b0;
        paddr          = 32'h0;
        lat_left       = 0;
        lat_cfg        = 1;
        lat_rand       = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);

        // Zero-wait streaming: 3 cycles per instruction
        rst = 1'b1;
        tick();
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        tick();
        chk("wait_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        chk("hold0_valid", 32'(inst_valid), 32'd1);
        chk("hold0_pc", inst_pc, 32'h0);
        chk("hold0_data", inst_data, memword(32'h0));
        tick();
        chk("req4_valid", 32'(imem_req_valid), 32'd1);
        chk("req4_addr", imem_req_addr, 32'h4);
        chk("req4_inst_valid", 32'(inst_valid), 32'd0);

        // Memory not ready: request held stable
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
            chk("stall_req_addr", imem_req_addr, 32'h4);
        end
        imem_req_ready = 1'b1;
        tick();
        tick();
        chk("hold4_pc", inst_pc, 32'h4);
        chk("hold4_data", inst_data, memword(32'h4));

        // Decode back-pressure: buffer held, no new request
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_inst_valid", 32'(inst_valid), 32'd1);
            chk("bp_inst_pc", inst_pc, 32'h4);
            chk("bp_inst_data", inst_data, memword(32'h4));
            chk("bp_no_req", 32'(imem_req_valid), 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        chk("req8_addr", imem_req_addr, 32'h8);

        // Redirect while waiting for 0x8
        lat_cfg = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("wait_redir_no_req", 32'(imem_req_valid), 32'd0);
        wait_req("wait_redir_req", 10, seen);
        chk("wait_redir_squashed", 32'(seen), 32'd0);
        chk("wait_redir_addr", imem_req_addr, 32'h100);
        lat_cfg = 1;
        wait_inst("wait_redir_inst", 10);
        chk("wait_redir_inst_pc", inst_pc, 32'h100);
        chk("wait_redir_inst_data", inst_data, memword(32'h100));

        // Redirect in HOLD with inst_ready high
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("hold_redir_squash", 32'(inst_valid), 32'd0);
        chk("hold_redir_addr", imem_req_addr, 32'h200);
        tick();
        tick();
        chk("hold_redir_inst_pc", inst_pc, 32'h200);
        tick();
        chk("hold_redir_next_addr", imem_req_addr, 32'h204);

        // Redirect while request is stalled
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("req_redir_stable_valid", 32'(imem_req_valid), 32'd1);
        chk("req_redir_stable_addr", imem_req_addr, 32'h204);
        imem_req_ready = 1'b1;
        tick();
        wait_req("req_redir_req", 10, seen);
        chk("req_redir_squashed", 32'(seen), 32'd0);
        chk("req_redir_addr", imem_req_addr, 32'h300);
        wait_inst("req_redir_inst", 10);
        chk("req_redir_inst_pc", inst_pc, 32'h300);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_inst("wrap_inst", 10);
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_next_addr", imem_req_addr, 32'h0);

        // Misaligned redirect
        wait_inst("mis_inst", 10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef YSYX_23060187_FETCH_MISALIGN_EN
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_inst_valid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("mis_no_req", 32'(imem_req_valid), 32'd0);
            tick();
        end
        chk("mis_fault_sticky", 32'(fetch_fault), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`else
        chk("mis_fault", 32'(fetch_fault), 32'd0);
        chk("mis_req_valid", 32'(imem_req_valid), 32'd1);
        chk("mis_req_addr", imem_req_addr, 32'h100);
`endif

        // Reset mid-fetch: stale response must be ignored
        lat_cfg = 3;
        tick();
        rst = 1'b0;
        #1;
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_rst_req_addr", imem_req_addr, 32'h0);
        tick();
        rst     = 1'b1;
        lat_cfg = 1;
        tick();
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_rst_req_addr", imem_req_addr, 32'h0);
        wait_inst("post_rst_inst", 10);
        chk("post_rst_inst_pc", inst_pc, 32'h0);
        chk("post_rst_inst_data", inst_data, memword(32'h0));

        // Randomized run against a fetch-stream model
        lat_rand = 1'b1;
        exp_pc   = 32'h0;
        consumed = 0;
        idle     = 0;
        p_rv = 1'b0; p_rr = 1'b0; p_iv = 1'b0; p_ir = 1'b0; p_redir = 1'b0;
        p_addr = 32'h0; p_ipc = 32'h0; p_idata = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_req_ready = ($urandom_range(99) < 70);
            inst_ready     = ($urandom_range(99) < 60);
            redirect_valid = ($urandom_range(99) < 4);
            r = $urandom;
            if ($urandom_range(15) == 0) r = r | 32'hFFFF_FFF0;
`ifdef YSYX_23060187_FETCH_MISALIGN_EN
            r = r & ~32'h3;
`endif
            redirect_pc = r;

            if (p_rv && !p_rr) begin
                chk("rnd_req_hold_valid", 32'(imem_req_valid), 32'd1);
                chk("rnd_req_hold_addr", imem_req_addr, p_addr);
            end
            if (p_iv && !p_ir && !p_redir) begin
                chk("rnd_inst_hold_valid", 32'(inst_valid), 32'd1);
                chk("rnd_inst_hold_pc", inst_pc, p_ipc);
                chk("rnd_inst_hold_data", inst_data, p_idata);
            end
            if (imem_req_valid) chk("rnd_one_outstanding", 32'(pend), 32'd0);
            if (inst_valid && inst_ready && !redirect_valid) begin
                chk("rnd_inst_pc", inst_pc, exp_pc);
                chk("rnd_inst_data", inst_data, memword(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
                idle = 0;
            end
            if (redirect_valid) exp_pc = r & ~32'h3;

            p_rv = imem_req_valid; p_rr = imem_req_ready; p_addr = imem_req_addr;
            p_iv = inst_valid; p_ir = inst_ready; p_redir = redirect_valid;
            p_ipc = inst_pc; p_idata = inst_data;

            tick();
            idle++;
            if (idle > 200) begin
                chk("rnd_stall_cycles", 32'(idle), 32'd200);
                break;
            end
        end
        redirect_valid = 1'b0;
        chk("rnd_progress", 32'(consumed > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
